// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding, mode constants and reset divisor for the divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clkdiv_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // Values of the mode input
  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  // Half-period divisor after reset: 6 device cycles per phase, 12 per period
  localparam int CLKDIV_DEFAULT_DIV = 5;

endpackage

// File: rtl/clk_phase_counter.sv
// clk_phase_counter: counts device cycles within one clk phase, flags count==div.
// Latency: tc is combinational from the registered count; clear/wrap take effect next cycle.
// Backpressure: none; enable simply holds the count.
module clk_phase_counter
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] count;

  // Terminal count marks the last device cycle of the current phase
  assign tc = (count == div);

  // Phase counter: clear wins, otherwise wrap to zero at terminal count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable half-period clock divider with free-run/step modes and runt-free stop.
// Latency: clk rises on the edge that leaves IDLE; each phase lasts div+1 device cycles; done one cycle after the last fall.
// Backpressure: none; enable/finish request a stop, which waits out a high phase when GLITCH_FREE=1.
module clock_divider_prog #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = clkdiv_pkg::CLKDIV_DEFAULT_DIV,
  parameter bit GLITCH_FREE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             finish,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] step_count,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             load_ack,
  output logic             clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  import clkdiv_pkg::*;

  state_t           state;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             pend_vld;
  logic [CNT_W-1:0] step_tgt;
  logic             done_arm;

  logic run_ok;
  logic active;
  logic tc;
  logic cnt_clr;
  logic fall_now;
  logic apply_pt;

  assign run_ok = enable & ~finish;
  assign active = (state == ST_RUN) || (state == ST_STEP);
  assign busy   = (state != ST_IDLE);

  // Counter is held at zero in IDLE and on any abort that drops clk immediately
  assign cnt_clr = (state == ST_IDLE) ||
                   (active && !run_ok && (!clk || !GLITCH_FREE));

  // A normal fall happens at terminal count while high, unless a hard stop pre-empts it
  assign fall_now = clk && tc &&
                    ((state == ST_STOP) || (active && (run_ok || GLITCH_FREE)));

  // Divisor may only change between phases: every IDLE cycle or on a fall edge
  assign apply_pt = (state == ST_IDLE) || fall_now;

  clk_phase_counter #(
    .DIV_W (DIV_W)
  ) u_phase_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (1'b1),
    .div    (div_act),
    .tc     (tc)
  );

  // Divisor shadow: a load at an apply point goes straight in, otherwise it waits in pending
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_act  <= DIV_W'(DEFAULT_DIV);
      div_pend <= '0;
      pend_vld <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (apply_pt) begin
        if (load) begin
          div_act  <= div_in;
          pend_vld <= 1'b0;
          load_ack <= 1'b1;
        end else if (pend_vld) begin
          div_act  <= div_pend;
          pend_vld <= 1'b0;
          load_ack <= 1'b1;
        end
      end else if (load) begin
        div_pend <= div_in;
        pend_vld <= 1'b1;
      end
    end
  end

  // Sequencer: state, output clock, edge strobes, rise counter and burst completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      clk       <= 1'b0;
      rise_stb  <= 1'b0;
      fall_stb  <= 1'b0;
      done      <= 1'b0;
      done_arm  <= 1'b0;
      step_tgt  <= '0;
      cycle_cnt <= '0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      done     <= done_arm;
      done_arm <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk <= 1'b0;
          if (run_ok && (mode == MODE_FREE)) begin
            state     <= ST_RUN;
            clk       <= 1'b1;
            rise_stb  <= 1'b1;
            cycle_cnt <= CNT_W'(1);
          end else if (run_ok && (mode == MODE_STEP) && start) begin
            if (step_count != '0) begin
              state     <= ST_STEP;
              step_tgt  <= step_count;
              clk       <= 1'b1;
              rise_stb  <= 1'b1;
              cycle_cnt <= CNT_W'(1);
            end else begin
              // Empty burst: report completion without producing any edge
              done <= 1'b1;
            end
          end
        end
        ST_RUN, ST_STEP: begin
          if (!run_ok) begin
            if (!clk) begin
              state <= ST_IDLE;
            end else if (GLITCH_FREE) begin
              if (tc) begin
                clk      <= 1'b0;
                fall_stb <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                state <= ST_STOP;
              end
            end else begin
              // Hard stop truncates the high phase and is not a real fall
              clk   <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (tc) begin
            clk <= ~clk;
            if (clk) begin
              fall_stb <= 1'b1;
              // cycle_cnt equals the number of periods begun; this fall closes the last one
              if ((state == ST_STEP) && (cycle_cnt == step_tgt)) begin
                state    <= ST_IDLE;
                done_arm <= 1'b1;
              end
            end else begin
              rise_stb  <= 1'b1;
              cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tc) begin
            clk      <= 1'b0;
            fall_stb <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          clk   <= 1'b0;
        end
      endcase
    end
  end

endmodule
